// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - steps the processor by running fetch then data access through one RAM port
module mem_responder #(
    parameter int AW   = 16,
    parameter int DW   = 16,
    parameter int WAIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [AW-1:0] pcaddr,
    output logic [DW-1:0] instruction,
    input  logic [AW-1:0] memaddr,
    output logic [DW-1:0] memdata,
    input  logic [DW-1:0] writedata,
    input  logic          memwrite,
    output logic          en,
    output logic          busy,
    output logic [15:0]   stepcount,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_cs,
    output logic          ram_we
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA,
        STEP
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT);

    state_t        state_q, state_d;
    logic [3:0]    wait_q, wait_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] memdata_q, memdata_d;
    logic [15:0]   step_q, step_d;
    logic          last_beat;

    assign last_beat   = (wait_q == WAIT_LAST);
    assign instruction = instr_q;
    assign memdata     = memdata_q;
    assign stepcount   = step_q;
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            instr_q   <= '0;
            memdata_q <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instr_q   <= instr_d;
            memdata_q <= memdata_d;
            step_q    <= step_d;
        end
    end

    // RAM strobes decode straight from the state so an async reset drops them without a clock.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        instr_d   = instr_q;
        memdata_d = memdata_q;
        step_d    = step_q;
        en        = 1'b0;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                    wait_d  = '0;
                end
            end
            FETCH: begin
                ram_cs   = 1'b1;
                ram_addr = pcaddr;
                if (last_beat) begin
                    instr_d = ram_rdata;
                    wait_d  = '0;
                    state_d = DATA;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            DATA: begin
                ram_cs    = 1'b1;
                ram_addr  = memaddr;
                ram_wdata = writedata;
                ram_we    = memwrite;
                if (last_beat) begin
                    if (!memwrite) begin
                        memdata_d = ram_rdata;
                    end
                    wait_d  = '0;
                    state_d = STEP;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            STEP: begin
                en      = 1'b1;
                step_d  = step_q + 16'd1;
                wait_d  = '0;
                state_d = run ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed bench for mem_responder at WAIT=0 and WAIT=3
module tb_mem_responder;

    localparam int W0 = 0;
    localparam int W1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        run [2];
    logic [15:0] pcaddr [2];
    logic [15:0] memaddr [2];
    logic [15:0] writedata [2];
    logic        memwrite [2];
    logic [15:0] instruction [2];
    logic [15:0] memdata [2];
    logic [15:0] stepcount [2];
    logic [15:0] ram_addr [2];
    logic [15:0] ram_wdata [2];
    logic [15:0] ram_rdata [2];
    logic        en [2];
    logic        busy [2];
    logic        ram_cs [2];
    logic        ram_we [2];

    logic [15:0] ram [2][256];
    logic        pl_en = 1'b0;
    bit          pl_d;
    logic [7:0]  pl_a;
    logic [15:0] pl_v;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: position within a step plus an ideal copy of each RAM.
    bit          m_act [2];
    int          m_t [2];
    logic [15:0] m_instr [2];
    logic [15:0] m_md [2];
    logic [15:0] m_cnt [2];
    logic [15:0] mm [2][256];

    mem_responder #(.AW(16), .DW(16), .WAIT(W0)) dut0 (
        .clk(clk), .rst(rst), .run(run[0]), .pcaddr(pcaddr[0]), .instruction(instruction[0]),
        .memaddr(memaddr[0]), .memdata(memdata[0]), .writedata(writedata[0]), .memwrite(memwrite[0]),
        .en(en[0]), .busy(busy[0]), .stepcount(stepcount[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]), .ram_cs(ram_cs[0]), .ram_we(ram_we[0])
    );

    mem_responder #(.AW(16), .DW(16), .WAIT(W1)) dut1 (
        .clk(clk), .rst(rst), .run(run[1]), .pcaddr(pcaddr[1]), .instruction(instruction[1]),
        .memaddr(memaddr[1]), .memdata(memdata[1]), .writedata(writedata[1]), .memwrite(memwrite[1]),
        .en(en[1]), .busy(busy[1]), .stepcount(stepcount[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]), .ram_cs(ram_cs[1]), .ram_we(ram_we[1])
    );

    assign ram_rdata[0] = ram[0][ram_addr[0][7:0]];
    assign ram_rdata[1] = ram[1][ram_addr[1][7:0]];

    always @(posedge clk) begin
        if (pl_en) ram[pl_d][pl_a] <= pl_v;
        for (int d = 0; d < 2; d++) begin
            if (ram_cs[d] && ram_we[d]) ram[d][ram_addr[d][7:0]] <= ram_wdata[d];
        end
    end

    function automatic int wv(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", d, name, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        m_act[d]   = 1'b0;
        m_t[d]     = 0;
        m_instr[d] = 16'h0;
        m_md[d]    = 16'h0;
        m_cnt[d]   = 16'h0;
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int w;
            w = wv(d);
            if (!rst) begin
                model_reset(d);
            end else if (!m_act[d]) begin
                if (run[d]) begin
                    m_act[d] = 1'b1;
                    m_t[d]   = 0;
                end
            end else begin
                if (m_t[d] == w) m_instr[d] = mm[d][pcaddr[d][7:0]];
                if (m_t[d] == 2 * w + 1) begin
                    if (memwrite[d]) mm[d][memaddr[d][7:0]] = writedata[d];
                    else m_md[d] = mm[d][memaddr[d][7:0]];
                end
                if (m_t[d] == 2 * w + 2) begin
                    m_cnt[d] = m_cnt[d] + 16'd1;
                    if (run[d]) m_t[d] = 0;
                    else m_act[d] = 1'b0;
                end else begin
                    m_t[d] = m_t[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int w;
            bit fe, da;
            w  = wv(d);
            fe = m_act[d] && (m_t[d] <= w);
            da = m_act[d] && (m_t[d] > w) && (m_t[d] <= 2 * w + 1);
            chk(d, "busy", 32'(busy[d]), 32'(m_act[d]));
            chk(d, "en", 32'(en[d]), 32'(m_act[d] && (m_t[d] == 2 * w + 2)));
            chk(d, "ram_cs", 32'(ram_cs[d]), 32'(fe || da));
            chk(d, "ram_we", 32'(ram_we[d]), 32'(da && memwrite[d]));
            chk(d, "ram_addr", 32'(ram_addr[d]), 32'(fe ? pcaddr[d] : (da ? memaddr[d] : 16'h0)));
            if (!fe) chk(d, "ram_wdata", 32'(ram_wdata[d]), 32'(da ? writedata[d] : 16'h0));
            chk(d, "instruction", 32'(instruction[d]), 32'(m_instr[d]));
            chk(d, "memdata", 32'(memdata[d]), 32'(m_md[d]));
            chk(d, "stepcount", 32'(stepcount[d]), 32'(m_cnt[d]));
        end
    end

    task automatic preload(input int d, input logic [7:0] a, input logic [15:0] v);
        pl_d  = (d != 0);
        pl_a  = a;
        pl_v  = v;
        pl_en = 1'b1;
        mm[d][a] = v;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic set_step(input int d, input logic [15:0] pc, input logic [15:0] ma,
                            input logic [15:0] wd, input logic mw);
        pcaddr[d]    = pc;
        memaddr[d]   = ma;
        writedata[d] = wd;
        memwrite[d]  = mw;
    endtask

    // Returns at the falling edge inside the en cycle.
    task automatic wait_en(input int d);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (en[d] !== 1'b1 && k < 200);
        if (en[d] !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d en_timeout: en still %b after %0d cycles, required 1", d, en[d], k);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int we1, we2, we3, en_n, cs_n, busy_n;
        int en_at [3];
        logic [15:0] old_v;

        rst = 1'b0;
        pl_d = 1'b0;
        pl_a = 8'h0;
        pl_v = 16'h0;
        for (int d = 0; d < 2; d++) begin
            run[d] = 1'b0;
            set_step(d, 16'h0, 16'h0, 16'h0, 1'b0);
            model_reset(d);
        end
        #1;
        chk(0, "reset_instruction", 32'(instruction[0]), 32'h0);
        chk(0, "reset_memdata", 32'(memdata[0]), 32'h0);
        chk(0, "reset_stepcount", 32'(stepcount[0]), 32'h0);
        chk(0, "reset_busy_en_cs_we", 32'({busy[0], en[0], ram_cs[0], ram_we[0]}), 32'h0);
        chk(1, "reset_addr_wdata", 32'({ram_addr[1], ram_wdata[1]}), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int a = 0; a < 256; a++) begin
            preload(0, 8'(a), 16'($urandom));
            preload(1, 8'(a), 16'($urandom));
        end

        // Load step at WAIT=0
        preload(0, 8'h00, 16'h1234);
        preload(0, 8'h40, 16'hBEEF);
        set_step(0, 16'h0000, 16'h0040, 16'h0000, 1'b0);
        run[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk(0, "load_fetch_addr", 32'(ram_addr[0]), 32'h0000);
        run[0] = 1'b0;
        @(negedge clk);
        chk(0, "load_data_addr", 32'(ram_addr[0]), 32'h0040);
        @(negedge clk);
        chk(0, "load_en", 32'(en[0]), 32'h1);
        chk(0, "load_instruction", 32'(instruction[0]), 32'h1234);
        chk(0, "load_memdata", 32'(memdata[0]), 32'hBEEF);
        @(negedge clk);
        chk(0, "load_stepcount", 32'(stepcount[0]), 32'h1);

        // Store step at WAIT=0
        set_step(0, 16'h0000, 16'h0010, 16'hA5A5, 1'b1);
        run[0] = 1'b1;
        @(negedge clk);
        we1 = int'(ram_we[0]);
        run[0] = 1'b0;
        @(negedge clk);
        we2 = int'(ram_we[0]);
        @(negedge clk);
        we3 = int'(ram_we[0]);
        @(negedge clk);
        chk(0, "store_we_pattern", 32'({we1[0], we2[0], we3[0]}), 32'b010);
        chk(0, "store_ram", 32'(ram[0][8'h10]), 32'hA5A5);
        chk(0, "store_memdata_kept", 32'(memdata[0]), 32'hBEEF);
        chk(0, "store_stepcount", 32'(stepcount[0]), 32'h2);

        // Self-modifying code
        preload(0, 8'h21, 16'h0BAD);
        set_step(0, 16'h0020, 16'h0021, 16'h7777, 1'b1);
        run[0] = 1'b1;
        wait_en(0);
        @(posedge clk);
        #1;
        set_step(0, 16'h0021, 16'h0022, 16'h0000, 1'b0);
        run[0] = 1'b0;
        wait_en(0);
        chk(0, "selfmod_instruction", 32'(instruction[0]), 32'h7777);
        chk(0, "selfmod_stepcount", 32'(stepcount[0]), 32'h3);
        @(negedge clk);

        // Reset during the DATA cycle of a store
        old_v = ram[0][8'h31];
        set_step(0, 16'h0030, 16'h0031, 16'h5555, 1'b1);
        run[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(0, "prereset_we", 32'(ram_we[0]), 32'h1);
        chk(0, "prereset_stepcount", 32'(stepcount[0]), 32'h4);
        rst = 1'b0;
        run[0] = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk(0, "abort_strobes", 32'({ram_we[0], ram_cs[0], en[0], busy[0]}), 32'h0);
        chk(0, "abort_instruction", 32'(instruction[0]), 32'h0);
        chk(0, "abort_memdata", 32'(memdata[0]), 32'h0);
        chk(0, "abort_stepcount", 32'(stepcount[0]), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk(0, "abort_no_write", 32'(ram[0][8'h31]), 32'(old_v));

        // Three back-to-back steps at WAIT=3
        set_step(1, 16'h0050, 16'h0051, 16'h0000, 1'b0);
        run[1] = 1'b1;
        en_n = 0;
        cs_n = 0;
        en_at = '{0, 0, 0};
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (en[1] === 1'b1) begin
                if (en_n < 3) en_at[en_n] = c;
                en_n++;
            end
            if (ram_cs[1] === 1'b1) cs_n++;
            if (c == 20) run[1] = 1'b0;
        end
        chk(1, "w3_en_count", 32'(en_n), 32'd3);
        chk(1, "w3_en_cycle1", 32'(en_at[0]), 32'd9);
        chk(1, "w3_en_cycle2", 32'(en_at[1]), 32'd18);
        chk(1, "w3_en_cycle3", 32'(en_at[2]), 32'd27);
        chk(1, "w3_cs_cycles", 32'(cs_n), 32'd24);
        chk(1, "w3_stepcount", 32'(stepcount[1]), 32'd3);

        // run dropped during the fetch of step 2
        set_step(1, 16'h0060, 16'h0061, 16'h0000, 1'b0);
        run[1] = 1'b1;
        wait_en(1);
        @(posedge clk);
        #1;
        set_step(1, 16'h0062, 16'h0063, 16'h3C3C, 1'b1);
        @(negedge clk);
        run[1] = 1'b0;
        wait_en(1);
        busy_n = 0;
        cs_n = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (busy[1] !== 1'b0) busy_n++;
            if (ram_cs[1] !== 1'b0) cs_n++;
        end
        chk(1, "drop_busy_after", 32'(busy_n), 32'd0);
        chk(1, "drop_cs_after", 32'(cs_n), 32'd0);
        chk(1, "drop_stepcount", 32'(stepcount[1]), 32'd5);
        chk(1, "drop_store_ram", 32'(ram[1][8'h63]), 32'h3C3C);
        set_step(1, 16'h0064, 16'h0065, 16'h0000, 1'b0);
        run[1] = 1'b1;
        @(negedge clk);
        chk(1, "restart_fetch_addr", 32'(ram_addr[1]), 32'h0064);
        chk(1, "restart_cs", 32'(ram_cs[1]), 32'h1);
        run[1] = 1'b0;
        wait_en(1);
        @(posedge clk);
        #1;

        // Randomized steps, checked every cycle against the model
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 40; s++) begin
                set_step(d, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                         16'($urandom), 1'($urandom_range(0, 1)));
                run[d] = 1'b1;
                @(negedge clk);
                @(negedge clk);
                run[d] = ($urandom_range(0, 3) != 0);
                wait_en(d);
                @(posedge clk);
                #1;
                if (!run[d]) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
            run[d] = 1'b0;
            repeat (12) @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's fetch and data ports, sitting between the processor and a single-ported external RAM. For each instruction step it:
- fetches the instruction at `pcaddr`;
- performs the data read or write at `memaddr`;
- pulses the processor's `en` for exactly one cycle with `instruction` and `memdata` held stable in registers.

The block sequences both accesses through one RAM port with a configurable number of wait states.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `WAIT`, 0, extra wait cycles per RAM access (0..15); each access occupies WAIT+1 cycles

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `run`  in  1  start/continue stepping the processor
- `pcaddr`  in  AW  instruction fetch address from the processor
- `instruction`  out  DW  registered fetched instruction
- `memaddr`  in  AW  data address from the processor
- `memdata`  out  DW  registered data read result
- `writedata`  in  DW  store data from the processor
- `memwrite`  in  1  1 = store this step, 0 = load
- `en`  out  1  one-cycle step pulse to the processor
- `busy`  out  1  state ≠ IDLE
- `stepcount`  out  16  number of completed steps, wraps
- `ram_addr`  out  AW  external RAM address
- `ram_wdata`  out  DW  external RAM write data
- `ram_rdata`  in  DW  external RAM read data
- `ram_cs`  out  1  external RAM access active
- `ram_we`  out  1  external RAM write enable

## Operation
- Reset (`rst`=0, asynchronous):
  - state IDLE;
  - `instruction`, `memdata`, `stepcount`, wait counter = 0;
  - `en`, `busy`, `ram_cs`, `ram_we` = 0;
  - `ram_addr`, `ram_wdata` = 0.
- FSM states: IDLE, FETCH, DATA, STEP.
  - IDLE: if `run`=1, go to FETCH and clear the wait counter.
  - FETCH: `ram_cs`=1, `ram_we`=0, `ram_addr`=`pcaddr`. Wait counter increments each cycle. When it equals WAIT, load `instruction` from `ram_rdata` at that edge, clear the counter, and go to DATA.
  - DATA: `ram_cs`=1, `ram_addr`=`memaddr`, `ram_wdata`=`writedata`, `ram_we`=`memwrite`, all for every cycle of the access. On the final cycle (counter = WAIT):
    - load: load `memdata` from `ram_rdata`;
    - store: `memdata` is unchanged.
    - Then go to STEP.
  - STEP: `en`=1 for this one cycle; `stepcount` increments at the end of the cycle. Next state is FETCH if `run`=1, otherwise IDLE.
- `ram_addr`, `ram_wdata`, `ram_we`, `ram_cs` are combinational decodes of state and processor ports. Outside FETCH/DATA they are all 0.
- The processor changes `pcaddr`/`memaddr`/`writedata`/`memwrite` only on `en` edges. Because of this, RAM address and data are stable for the whole access. `memaddr` may depend combinationally on `instruction`; the new `instruction` is registered at the FETCH→DATA edge, so `memaddr` is valid from the first DATA cycle.
- `run` is sampled only in IDLE and STEP. Deasserting `run` mid-step completes the current step, including its `en` pulse, then idles.
- A store to the address of the next fetch: the next FETCH returns the newly written value, since the RAM port is shared.

## Timing
- Step length is 2·(WAIT+1)+1 cycles: 3 cycles at WAIT=0, 9 cycles at WAIT=3.
- Back-to-back steps with `run` held at 1: `en` pulses every 2·(WAIT+1)+1 cycles and never on consecutive cycles.
- `ram_rdata` is sampled at the rising edge that ends the last cycle of an access. The RAM must present read data within WAIT+1 cycles of address.
- `instruction`/`memdata` hold from their load edge through the `en` cycle and until the next load edge.
- Reset mid-access forces `ram_cs`/`ram_we` low immediately (no clock needed). No `en` pulse is generated for the aborted step. After `rst` rises, the block restarts from IDLE.
- `stepcount` wraps from 0xFFFF to 0x0000.

## Test plan
- Reset: drive `rst`=0 mid-DATA with a store in progress → `ram_we`, `ram_cs`, `en`, `busy` go to 0 before the next edge. All registered outputs read 0, and `stepcount` resets from its previous nonzero value to 0.
- Load step, WAIT=0, RAM[0x0000]=0x1234, RAM[0x0040]=0xBEEF, processor `memaddr`=0x0040, `memwrite`=0:
  - `run`=1 → `ram_addr`=0x0000 in cycle 1 and 0x0040 in cycle 2;
  - `en`=1 in cycle 3 with `instruction`=0x1234 and `memdata`=0xBEEF;
  - `stepcount`=1 after cycle 3.
- Store step, WAIT=0, `memaddr`=0x0010, `writedata`=0xA5A5, `memwrite`=1:
  - `ram_we`=1 only in the DATA cycle, and RAM[0x0010]=0xA5A5 afterwards;
  - `memdata` retains its prior value.
- Wait states, WAIT=3, `run` held at 1 for 3 steps: `en` asserted at cycles 9, 18, 27; `ram_cs` high for 4 consecutive cycles per access; `stepcount`=3.
- `run` dropped during FETCH of step 2 → step 2 completes with its `en` pulse, then `busy`=0 with no further `ram_cs` activity. `run` reasserted → the next step starts from the current `pcaddr`.
- Self-modifying code: a store of 0x7777 to the address of the next instruction → the next fetch returns `instruction`=0x7777.
